// File: rtl/ccff_chain_pkg.sv
// ---------------------------------------------------------------------------
// ccff_chain_pkg : shared types and helpers for the config-chain driver
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ccff_chain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_READ = 1'b1;

  function automatic int words_per_chain(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ccff_chain_driver.sv
// ---------------------------------------------------------------------------
// ccff_chain_driver : serialises bitstream words into a CCFF chain and
// performs non-destructive rotate-readback packed into words.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ccff_chain_driver
  import ccff_chain_pkg::*;
#(
  parameter int CHAIN_LEN = 29,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              mode,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
);

  localparam int WPC       = words_per_chain(CHAIN_LEN, WORD_W);
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int BC_W      = $clog2(WORD_W + 1);
  localparam int WA_W      = $clog2(WPC + 1);
  localparam int LAST_BITS = CHAIN_LEN - (WPC - 1) * WORD_W;

  localparam logic [CNT_W-1:0] CLEN   = CNT_W'(CHAIN_LEN);
  localparam logic [BC_W-1:0]  WFULL  = BC_W'(WORD_W);
  localparam logic [BC_W-1:0]  WLAST  = BC_W'(LAST_BITS);
  localparam logic [WA_W-1:0]  NWORDS = WA_W'(WPC);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic [BC_W-1:0]     bcnt_q, bcnt_d;
  logic [WA_W-1:0]     words_q, words_d;
  logic                head_q, head_d;
  logic                shift_en_q, shift_en_d;
  logic [WORD_W-1:0]   pk_q, pk_d, pk_base;
  logic [BC_W-1:0]     pkcnt_q, pkcnt_d, pkcnt_base;
  logic [WORD_W-1:0]   rb_data_q, rb_data_d;
  logic                rb_valid_q, rb_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic w_load_shift, w_all_captured, w_move;

  assign w_load_shift   = (state_q == LOAD) && (bcnt_q != '0);
  // Every issued shift has been captured once no shift is still in flight.
  assign w_all_captured = (cnt_q == CLEN) && !shift_en_q;
  assign w_move         = (state_q == READ)
                       && ((pkcnt_q == WFULL) || (w_all_captured && (pkcnt_q != '0)))
                       && (!rb_valid_q || rb_ready);

  assign word_ready = (state_q == LOAD)
                   && ((bcnt_q == '0) || ((bcnt_q == BC_W'(1)) && w_load_shift))
                   && (words_q < NWORDS);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    bcnt_d     = bcnt_q;
    words_d    = words_q;
    head_d     = head_q;
    shift_en_d = 1'b0;
    pk_d       = pk_q;
    pkcnt_d    = pkcnt_q;
    pk_base    = pk_q;
    pkcnt_base = pkcnt_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = rb_valid_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (mode == MODE_READ) ? READ : LOAD;
          cnt_d   = '0;
          bcnt_d  = '0;
          words_d = '0;
          pk_d    = '0;
          pkcnt_d = '0;
        end
      end

      LOAD: begin
        if (w_load_shift) begin
          shift_en_d = 1'b1;
          head_d     = buf_q[WORD_W-1];
          buf_d      = buf_q << 1;
          bcnt_d     = bcnt_q - 1'b1;
          cnt_d      = cnt_q + 1'b1;
        end
        // A refill may coincide with the last bit leaving, so no bubble.
        if (word_ready && word_valid) begin
          buf_d   = word_in;
          bcnt_d  = (words_q == NWORDS - 1'b1) ? WLAST : WFULL;
          words_d = words_q + 1'b1;
        end
        if (cnt_q == CLEN) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      READ: begin
        if (rb_valid_q && rb_ready) rb_valid_d = 1'b0;
        if (w_move) begin
          rb_data_d  = pk_q << (WFULL - pkcnt_q);
          rb_valid_d = 1'b1;
          pk_base    = '0;
          pkcnt_base = '0;
        end
        if (shift_en_q) begin
          pk_d    = {pk_base[WORD_W-2:0], ccff_tail};
          pkcnt_d = pkcnt_base + 1'b1;
        end else begin
          pk_d    = pk_base;
          pkcnt_d = pkcnt_base;
        end
        // Stall when both the packer and the holding register will be full.
        if ((cnt_q != CLEN) && !((pkcnt_d == WFULL) && rb_valid_d)) begin
          shift_en_d = 1'b1;
          cnt_d      = cnt_q + 1'b1;
        end
        if (w_all_captured && (pkcnt_q == '0) && (!rb_valid_q || rb_ready)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      buf_q      <= '0;
      bcnt_q     <= '0;
      words_q    <= '0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
      pk_q       <= '0;
      pkcnt_q    <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      bcnt_q     <= bcnt_d;
      words_q    <= words_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
      pk_q       <= pk_d;
      pkcnt_q    <= pkcnt_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ccff_head     = (state_q == READ) ? ccff_tail : head_q;
  assign ccff_shift_en = shift_en_q;
  assign rb_data       = rb_data_q;
  assign rb_valid      = rb_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

`default_nettype wire
